// File: rtl/fft_mag_buffer.sv
// fft_mag_buffer
// Converts the FFT core's complex bin stream to approximate magnitudes
// (|re| + |im|, saturated) and stores each frame in one half of a ping-pong
// bin memory. A complete, correctly sized frame is committed to the peak
// sampler by swapping banks and pulsing sampler_start. The sampler reads the
// committed bank through a registered read port while the next frame fills
// the other bank.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   fft_tdata         {imag, real}, two's complement, DATA_W bits each
//   fft_tvalid/tlast  stream beat valid / last bin of frame
//   fft_tready        always 1 out of reset (never backpressures)
//   rd_addr, rd_en    sampler read request into the read bank
//   rd_data           registered read data, holds when rd_en=0
//   sampler_start     1-cycle pulse, new frame committed
//   sampler_done      1-cycle pulse from sampler, read bank released
//   frame_error       1-cycle pulse, frame length mismatch (frame discarded)
//   drop_count        saturating count of good frames dropped while busy
module fft_mag_buffer #(
  parameter int NUM_BINS = 1024,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int DROP_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*DATA_W-1:0] fft_tdata,
  input  logic                fft_tvalid,
  input  logic                fft_tlast,
  output logic                fft_tready,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_en,
  output logic [DATA_W-1:0]   rd_data,
  output logic                sampler_start,
  input  logic                sampler_done,
  output logic                frame_error,
  output logic [DROP_W-1:0]   drop_count
);

  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_BUSY = 1'b1;

  // Sign-extend by one bit so that the most negative value has a
  // representable magnitude (|-2^(DATA_W-1)| = 2^(DATA_W-1)).
  function automatic logic [DATA_W:0] abs_ext(input logic [DATA_W-1:0] v);
    logic [DATA_W:0] x;
    x = {v[DATA_W-1], v};
    return v[DATA_W-1] ? (~x + 1'b1) : x;
  endfunction

  // ---------------------------------------------------------------- input
  logic              accept;
  logic              at_end;
  logic              skip;        // discarding the tail of a long frame
  logic [ADDR_W-1:0] wr_idx;
  logic              beat_write;
  logic              beat_commit;
  logic              beat_err;

  assign fft_tready  = rst_n;
  assign accept      = fft_tvalid && fft_tready;
  assign at_end      = (wr_idx == ADDR_W'(NUM_BINS - 1));
  // A beat at the last index without tlast is the start of an overlong
  // frame; it is not written.
  assign beat_write  = accept && !skip && (fft_tlast || !at_end);
  assign beat_commit = accept && !skip && fft_tlast && at_end;
  assign beat_err    = accept && !skip && (fft_tlast != at_end);

  // NOTE: every clocked block uses non-blocking assignments so that all
  // registers sample their inputs from the same pre-edge state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx      <= '0;
      skip        <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= beat_err;
      if (accept) begin
        if (skip) begin
          if (fft_tlast) skip <= 1'b0;
        end else if (fft_tlast || at_end) begin
          wr_idx <= '0;
          if (!fft_tlast) skip <= 1'b1;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------- pipeline
  logic              s1_valid, s1_commit;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W:0]   s1_re_abs, s1_im_abs;
  logic              s2_valid, s2_commit;
  logic [ADDR_W-1:0] s2_addr;
  logic [DATA_W-1:0] s2_mag;
  logic              s3_commit;
  logic [DATA_W+1:0] mag_sum;

  assign mag_sum = {1'b0, s1_re_abs} + {1'b0, s1_im_abs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_commit <= 1'b0;
      s1_addr   <= '0;
      s1_re_abs <= '0;
      s1_im_abs <= '0;
      s2_valid  <= 1'b0;
      s2_commit <= 1'b0;
      s2_addr   <= '0;
      s2_mag    <= '0;
      s3_commit <= 1'b0;
    end else begin
      s1_valid  <= beat_write;
      s1_commit <= beat_commit;
      s1_addr   <= wr_idx;
      s1_re_abs <= abs_ext(fft_tdata[DATA_W-1:0]);
      s1_im_abs <= abs_ext(fft_tdata[2*DATA_W-1:DATA_W]);
      s2_valid  <= s1_valid;
      s2_commit <= s1_valid && s1_commit;
      s2_addr   <= s1_addr;
      s2_mag    <= (mag_sum[DATA_W+1:DATA_W] != 2'b00) ? '1 : mag_sum[DATA_W-1:0];
      s3_commit <= s2_valid && s2_commit;
    end
  end

  // ------------------------------------------------------------ read side
  logic [0:0] rd_state;
  logic       wr_bank;
  logic       commit_go;
  logic       wr_sel;

  // sampler_done arriving with a commit frees the bank just in time.
  assign commit_go = s3_commit && ((rd_state == RD_IDLE) || sampler_done);
  // A write landing on the swap edge already belongs to the next frame, so
  // it must go to the bank that becomes the write bank on that edge.
  assign wr_sel    = commit_go ? ~wr_bank : wr_bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state      <= RD_IDLE;
      wr_bank       <= 1'b0;
      sampler_start <= 1'b0;
      drop_count    <= '0;
    end else begin
      sampler_start <= 1'b0;
      if (commit_go) begin
        wr_bank       <= ~wr_bank;
        sampler_start <= 1'b1;
        rd_state      <= RD_BUSY;
      end else if (s3_commit) begin
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end else if (sampler_done && (rd_state == RD_BUSY)) begin
        rd_state <= RD_IDLE;
      end
    end
  end

  // --------------------------------------------------------------- memory
  logic [DATA_W-1:0] mem [0:2*NUM_BINS-1];

  // NOTE: the bin memory has no reset; every location is written before the
  // bank holding it is ever committed, and a reset would prevent RAM mapping.
  always_ff @(posedge clk) begin
    if (s2_valid) mem[{wr_sel, s2_addr}] <= s2_mag;
  end

  // The read bank is sampled before any swap on this edge takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[{~wr_bank, rd_addr}];
    end
  end

endmodule

// File: tb/tb_fft_mag_buffer.sv
module tb_fft_mag_buffer;

  localparam int NB = 1024;
  localparam int K_START = 0, K_ERR = 1, K_DROP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fft_tdata = '0;
  logic        fft_tvalid = 1'b0, fft_tlast = 1'b0;
  logic        fft_tready;
  logic [9:0]  rd_addr = '0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        sampler_start, sampler_done = 1'b0, frame_error;
  logic [7:0]  drop_count;

  fft_mag_buffer dut (
    .clk(clk), .rst_n(rst_n), .fft_tdata(fft_tdata), .fft_tvalid(fft_tvalid),
    .fft_tlast(fft_tlast), .fft_tready(fft_tready), .rd_addr(rd_addr),
    .rd_en(rd_en), .rd_data(rd_data), .sampler_start(sampler_start),
    .sampler_done(sampler_done), .frame_error(frame_error),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------ reference model
  typedef struct { int kind; int cyc; int val; } ev_t;
  ev_t evq[$];
  int  rdq[$];
  int  frm[NB];        // frame being received
  int  rdm[NB];        // contents of the committed (read) bank
  int  cnt = 0;
  bit  skipping = 0;
  bit  busy = 0;
  bit  same_done = 0;  // sampler_done will coincide with the next commit
  int  drops = 0;

  function automatic int mag(int re, int im);
    int a, b, s;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    s = a + b;
    return (s > 65535) ? 65535 : s;
  endfunction

  function automatic void push_ev(int kind, int c, int v);
    ev_t e;
    e.kind = kind; e.cyc = c; e.val = v;
    evq.push_back(e);
  endfunction

  // t = cycle number of the edge that accepts the beat
  function automatic void model_beat(int re, int im, bit last, int t);
    if (skipping) begin
      if (last) skipping = 0;
      return;
    end
    frm[cnt] = mag(re, im);
    if (last) begin
      if (cnt == NB - 1) begin
        if (!busy || same_done) begin
          rdm = frm;
          busy = 1;
          push_ev(K_START, t + 3, 0);
        end else begin
          drops = (drops == 255) ? 255 : drops + 1;
          push_ev(K_DROP, t + 3, drops);
        end
      end else begin
        push_ev(K_ERR, t, 0);
      end
      cnt = 0;
    end else if (cnt == NB - 1) begin
      push_ev(K_ERR, t, 0);
      skipping = 1;
      cnt = 0;
    end else begin
      cnt++;
    end
  endfunction

  // -------------------------------------------------------------- monitor
  logic rd_pend;
  int   prev_drop = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= rd_en;

  task automatic got(int kind, int val);
    ev_t e;
    if (evq.size() == 0) begin
      check("unexpected_event_kind", kind, -1);
    end else begin
      e = evq.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
      if (kind == K_DROP) check("drop_count", val, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_drop = 0;
    end else begin
      if (sampler_start) got(K_START, 0);
      if (frame_error) got(K_ERR, 0);
      if (int'(drop_count) != prev_drop) begin
        prev_drop = int'(drop_count);
        got(K_DROP, prev_drop);
      end
      if (rd_pend) begin
        if (rdq.size() == 0) check("rd_unexpected", int'(rd_data), -1);
        else check("rd_data", int'(rd_data), rdq.pop_front());
      end
    end
  end

  // ------------------------------------------------------------- drivers
  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      fft_tvalid = 1'b0;
      fft_tlast  = 1'b0;
    end
  endtask

  task automatic drive_beat(int re, int im, bit last);
    logic [31:0] rv, iv;
    @(posedge clk); #1;
    rv = re; iv = im;
    fft_tdata  = {iv[15:0], rv[15:0]};
    fft_tvalid = 1'b1;
    fft_tlast  = last;
    model_beat(re, im, last, cyc + 1);
  endtask

  // kind 0: re=bin, 1: random, 2: corner values then random, 3: re=2000+bin
  task automatic send_frame(int kind, int n, bit gaps);
    int re, im;
    for (int i = 0; i < n; i++) begin
      re = 0; im = 0;
      case (kind)
        0: re = i;
        3: re = 2000 + i;
        default: begin
          re = int'($urandom_range(65535)) - 32768;
          im = int'($urandom_range(65535)) - 32768;
        end
      endcase
      if (kind == 2 && i == 0) begin re = -32768; im = -32768; end
      if (kind == 2 && i == 1) begin re = -3;     im = 4;      end
      if (kind == 2 && i == 2) begin re = 32767;  im = 1;      end
      if (gaps && $urandom_range(1) == 1) idle(1);
      drive_beat(re, im, i == n - 1);
    end
    idle(1);
  endtask

  task automatic done_pulse();
    @(posedge clk); #1 sampler_done = 1'b1;
    @(posedge clk); #1 sampler_done = 1'b0;
    if (busy) busy = 0;
  endtask

  int last_rd = 0;

  task automatic rd(int a);
    @(posedge clk); #1;
    rd_en   = 1'b1;
    rd_addr = 10'(a);
    rdq.push_back(rdm[a]);
    last_rd = rdm[a];
  endtask

  task automatic rd_end();
    @(posedge clk); #1;
    rd_en   = 1'b0;
    rd_addr = rd_addr + 10'd7;
    @(posedge clk); #1;
    check("rd_hold", int'(rd_data), last_rd);
  endtask

  task automatic rd_random(int n);
    for (int i = 0; i < n; i++) rd(int'($urandom_range(NB - 1)));
    rd_end();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_tready"}, int'(fft_tready), 0);
    check({tag, "_start"}, int'(sampler_start), 0);
    check({tag, "_ferr"}, int'(frame_error), 0);
    check({tag, "_drop"}, int'(drop_count), 0);
    check({tag, "_rd_data"}, int'(rd_data), 0);
  endtask

  // ------------------------------------------------------------ sequence
  initial begin
    #3 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("tready_after_reset", int'(fft_tready), 1);

    // Ramp frame, read side idle: commits.
    send_frame(0, NB, 0);
    idle(6);
    rd(5); rd(1023); rd(0); rd(512);
    rd_end();
    rd_random(8);

    // Good frame while busy: dropped, read bank unchanged.
    send_frame(1, NB, 0);
    idle(6);
    rd(5); rd(1023);
    rd_end();
    done_pulse();
    idle(4);

    // Corner magnitudes with ~50% tvalid gaps.
    send_frame(2, NB, 1);
    idle(6);
    rd(0); rd(1); rd(2); rd(1023);
    rd_end();
    rd_random(16);
    done_pulse();
    idle(4);

    // Short frame, then a good frame starting at bin 0.
    send_frame(1, 501, 0);
    idle(6);
    send_frame(3, NB, 0);
    idle(6);
    rd(0); rd(1); rd(1023);
    rd_end();
    done_pulse();
    idle(4);

    // Long frame, then a good frame with gaps.
    send_frame(1, NB + 6, 0);
    idle(6);
    send_frame(1, NB, 1);
    idle(6);
    rd_random(12);

    // sampler_done on the commit cycle (read side busy): commit wins.
    same_done = 1;
    send_frame(1, NB, 0);
    same_done = 0;
    idle(1);
    @(posedge clk); #1 sampler_done = 1'b1;
    @(posedge clk); #1 sampler_done = 1'b0;
    idle(6);
    rd_random(12);

    // Reset in the middle of a frame.
    for (int i = 0; i < 300; i++) drive_beat(i + 7, 3, 1'b0);
    @(posedge clk); #3 rst_n = 1'b0;
    fft_tvalid = 1'b0;
    #1 check_reset_outputs("midreset");
    cnt = 0; skipping = 0; busy = 0; drops = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    send_frame(0, NB, 1);
    idle(6);
    rd(0); rd(5); rd(1023);
    rd_end();
    idle(4);

    check("events_outstanding", evq.size(), 0);
    check("reads_outstanding", rdq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
